mfp_ahb_xbar_n: RTL and testbench

Parametrised AHB-lite single-master interconnect for the MIPSfpga platform. Replaces the fixed three-slave decoder/mux with N_SLV address-matched slaves and a registered data-phase select. Adds true wait-state support (per-slave HREADYOUT), an internal default slave that returns a two-cycle AHB ERROR for unmapped accesses, and an optional stall-timeout watchdog. It sits between the MIPS core's AHB master port and the RAM, GPIO, seven-segment and Rojobot slaves.

---
 rtl/mfp_ahb_xbar_n_if.sv | 38 +++
 rtl/mfp_ahb_xbar_n.sv | 239 +++++++++++++++++++++++
 tb/tb_mfp_ahb_xbar_n.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mfp_ahb_xbar_n_if.sv
// ---------------------------------------------------------------------------
// mfp_ahb_xbar_n_if
// Bus bundle between the AHB-lite master, the crossbar and its N_SLV slaves.
//
// Signals:
//   HADDR, HTRANS            master address phase
//   HRDATA, HREADY, HRESP    muxed data-phase response back to the master
//   HSEL_S                   one-hot slave select (address phase)
//   HREADYOUT_S, HRESP_S     per-slave ready / response
//   HRDATA_S                 packed per-slave read data, slave i at [32i+31:32i]
//
// Modports:
//   slave  - the crossbar's view (it is the slave of the CPU master port)
//   master - the environment's view (CPU master plus the slave devices)
// ---------------------------------------------------------------------------
interface mfp_ahb_xbar_n_if #(
  parameter int N_SLV = 6
) ();
  logic [31:0]         HADDR;
  logic [1:0]          HTRANS;
  logic [31:0]         HRDATA;
  logic                HREADY;
  logic                HRESP;
  logic [N_SLV-1:0]    HSEL_S;
  logic [N_SLV-1:0]    HREADYOUT_S;
  logic [N_SLV-1:0]    HRESP_S;
  logic [N_SLV*32-1:0] HRDATA_S;

  modport slave (
    input  HADDR, HTRANS, HREADYOUT_S, HRESP_S, HRDATA_S,
    output HRDATA, HREADY, HRESP, HSEL_S
  );

  modport master (
    output HADDR, HTRANS, HREADYOUT_S, HRESP_S, HRDATA_S,
    input  HRDATA, HREADY, HRESP, HSEL_S
  );
endinterface

// File: rtl/mfp_ahb_xbar_n.sv
// ---------------------------------------------------------------------------
// mfp_ahb_xbar_n
// Single-master AHB-lite interconnect with N_SLV address-matched slaves, a
// registered data-phase select, per-slave wait states and an internal default
// slave that answers unmapped accesses with a two-cycle ERROR.
//
// Ports:
//   HCLK     bus clock
//   HRESET   synchronous active-high reset
//   bus      mfp_ahb_xbar_n_if.slave (master address phase, muxed response,
//            slave selects, per-slave ready/response/read data)
//   TO_CLR   clears TO_FLAG / TO_SLV (timeout build only)
//   TO_FLAG  sticky stall-timeout flag (0 without timeout)
//   TO_SLV   index of the last slave that timed out (0 without timeout)
//
// Build option:
//   MFP_AHB_XBAR_TIMEOUT_EN - when defined, a slave stalling the bus for
//   TIMEOUT_CYCLES cycles is aborted and the master receives ERROR.
// ---------------------------------------------------------------------------
module mfp_ahb_xbar_n #(
  parameter int                  N_SLV          = 6,
  parameter logic [N_SLV*32-1:0] SLV_BASE       = {N_SLV{32'h0}},
  parameter logic [N_SLV*32-1:0] SLV_MASK       = {N_SLV{32'h0}},
  parameter int                  TIMEOUT_CYCLES = 256
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  mfp_ahb_xbar_n_if.slave        bus,
  input  logic                   TO_CLR,
  output logic                   TO_FLAG,
  output logic [3:0]             TO_SLV
);

  typedef enum logic [1:0] {
    DSEL_NONE = 2'd0,
    DSEL_SLV  = 2'd1,
    DSEL_DEF  = 2'd2
  } dsel_kind_t;

  typedef enum logic [1:0] {
    ERR_IDLE = 2'd0,
    ERR1     = 2'd1,
    ERR2     = 2'd2
  } err_state_t;

  dsel_kind_t       dsel_kind_r, dsel_kind_nxt_s;
  logic [3:0]       dsel_idx_r,  dsel_idx_nxt_s;
  err_state_t       err_state_r, err_state_nxt_s;

  logic             match_any_s;
  logic [3:0]       match_idx_s;
  logic [N_SLV-1:0] hsel_s;
  logic             ready_s;
  logic             resp_s;
  logic [31:0]      rdata_s;
  logic             load_def_s;
  logic             to_hit_s;

  // Address decode: scan from the top so the lowest matching index wins.
  always_comb begin
    match_any_s = 1'b0;
    match_idx_s = 4'd0;
    hsel_s      = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((bus.HADDR & SLV_MASK[i*32 +: 32]) ==
          (SLV_BASE[i*32 +: 32] & SLV_MASK[i*32 +: 32])) begin
        match_any_s = 1'b1;
        match_idx_s = 4'(i);
      end else begin
        match_any_s = match_any_s;
      end
    end
    for (int i = 0; i < N_SLV; i++) begin
      hsel_s[i] = match_any_s && (match_idx_s == 4'(i));
    end
  end

  assign bus.HSEL_S = hsel_s;

  // Data-phase response mux driven by the registered select.
  always_comb begin
    ready_s = 1'b1;
    resp_s  = 1'b0;
    rdata_s = 32'h0;
    case (dsel_kind_r)
      DSEL_SLV: begin
        for (int i = 0; i < N_SLV; i++) begin
          if (dsel_idx_r == 4'(i)) begin
            ready_s = bus.HREADYOUT_S[i];
            resp_s  = bus.HRESP_S[i];
            rdata_s = bus.HRDATA_S[i*32 +: 32];
          end else begin
            ready_s = ready_s;
          end
        end
      end
      DSEL_DEF: begin
        case (err_state_r)
          ERR1: begin
            ready_s = 1'b0;
            resp_s  = 1'b1;
          end
          ERR2: begin
            ready_s = 1'b1;
            resp_s  = 1'b1;
          end
          default: begin
            ready_s = 1'b1;
            resp_s  = 1'b0;
          end
        endcase
      end
      default: begin
        ready_s = 1'b1;
        resp_s  = 1'b0;
      end
    endcase
  end

  assign bus.HREADY = ready_s;
  assign bus.HRESP  = resp_s;
  assign bus.HRDATA = rdata_s;

  // An active unmapped address accepted this cycle starts the default slave.
  assign load_def_s = ready_s && bus.HTRANS[1] && !match_any_s;

`ifdef MFP_AHB_XBAR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] to_cnt_r;
  logic             to_flag_r;
  logic [3:0]       to_slv_r;
  logic             stalled_s;
  logic             unused_ok_s;

  // ready_s low with a real slave selected means that slave is holding us.
  assign stalled_s   = (dsel_kind_r == DSEL_SLV) && !ready_s;
  assign to_hit_s    = stalled_s && (to_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
  assign unused_ok_s = bus.HTRANS[0];

  // Stall counter and sticky timeout status; a new timeout beats TO_CLR.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      to_cnt_r  <= '0;
      to_flag_r <= 1'b0;
      to_slv_r  <= 4'd0;
    end else begin
      if (ready_s || to_hit_s) begin
        to_cnt_r <= '0;
      end else if (stalled_s) begin
        to_cnt_r <= to_cnt_r + CNT_W'(1);
      end else begin
        to_cnt_r <= to_cnt_r;
      end
      if (to_hit_s) begin
        to_flag_r <= 1'b1;
        to_slv_r  <= dsel_idx_r;
      end else if (TO_CLR) begin
        to_flag_r <= 1'b0;
        to_slv_r  <= 4'd0;
      end else begin
        to_flag_r <= to_flag_r;
        to_slv_r  <= to_slv_r;
      end
    end
  end

  assign TO_FLAG = to_flag_r;
  assign TO_SLV  = to_slv_r;
`else
  logic unused_ok_s;

  assign to_hit_s    = 1'b0;
  assign TO_FLAG     = 1'b0;
  assign TO_SLV      = 4'd0;
  assign unused_ok_s = ^{TO_CLR, bus.HTRANS[0], TIMEOUT_CYCLES[0]};
`endif

  // Next data-phase select and error FSM state.
  always_comb begin
    dsel_kind_nxt_s = dsel_kind_r;
    dsel_idx_nxt_s  = dsel_idx_r;
    err_state_nxt_s = err_state_r;

    if (to_hit_s) begin
      // Abort the stalled slave; the default slave finishes the transfer.
      dsel_kind_nxt_s = DSEL_DEF;
    end else if (ready_s) begin
      if (!bus.HTRANS[1]) begin
        dsel_kind_nxt_s = DSEL_NONE;
      end else if (match_any_s) begin
        dsel_kind_nxt_s = DSEL_SLV;
        dsel_idx_nxt_s  = match_idx_s;
      end else begin
        dsel_kind_nxt_s = DSEL_DEF;
      end
    end else begin
      dsel_kind_nxt_s = dsel_kind_r;
    end

    case (err_state_r)
      ERR_IDLE: begin
        if (to_hit_s || load_def_s) begin
          err_state_nxt_s = ERR1;
        end else begin
          err_state_nxt_s = ERR_IDLE;
        end
      end
      ERR1: begin
        err_state_nxt_s = ERR2;
      end
      ERR2: begin
        // Address phase taken during ERR2 may itself be unmapped.
        if (load_def_s) begin
          err_state_nxt_s = ERR1;
        end else begin
          err_state_nxt_s = ERR_IDLE;
        end
      end
      default: begin
        err_state_nxt_s = ERR_IDLE;
      end
    endcase
  end

  // Select and error FSM state registers.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dsel_kind_r <= DSEL_NONE;
      dsel_idx_r  <= 4'd0;
      err_state_r <= ERR_IDLE;
    end else begin
      dsel_kind_r <= dsel_kind_nxt_s;
      dsel_idx_r  <= dsel_idx_nxt_s;
      err_state_r <= err_state_nxt_s;
    end
  end

endmodule

// File: tb/tb_mfp_ahb_xbar_n.sv
// ---------------------------------------------------------------------------
// tb_mfp_ahb_xbar_n
// Self-checking bench for mfp_ahb_xbar_n: a directed vector table, a few
// hand-written multi-cycle sequences (reset in ERR1 / stall, long stall or
// timeout) and a randomized run against a transfer-level reference model.
// ---------------------------------------------------------------------------
module tb_mfp_ahb_xbar_n;

  localparam int NS = 6;

  // Masks drop the kseg bits so 0xBFxxxxxx hits the 0x1Fxxxxxx windows.
  // Slave 5 overlaps slaves 2..4; the lower index must win.
  localparam logic [NS*32-1:0] BASE = {32'h1F700000, 32'h1F720000, 32'h1F710000,
                                       32'h1F700000, 32'h1F800000, 32'h00000000};
  localparam logic [NS*32-1:0] MASK = {32'h1FF00000, 32'h1FFF0000, 32'h1FFF0000,
                                       32'h1FFF0000, 32'h1FFFFFFC, 32'h1FF00000};

  // Independent copy of the memory map for the reference model.
  logic [31:0] m_base [NS] = '{32'h00000000, 32'h1F800000, 32'h1F700000,
                               32'h1F710000, 32'h1F720000, 32'h1F700000};
  logic [31:0] m_mask [NS] = '{32'h1FF00000, 32'h1FFFFFFC, 32'h1FFF0000,
                               32'h1FFF0000, 32'h1FFF0000, 32'h1FF00000};

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        TO_CLR;
  logic        TO_FLAG;
  logic [3:0]  TO_SLV;
  logic [31:0] sdata [NS];

  int total = 0;
  int bad   = 0;

  always #5 HCLK = ~HCLK;

  mfp_ahb_xbar_n_if #(.N_SLV(NS)) bus ();

  assign bus.HRDATA_S = {sdata[5], sdata[4], sdata[3], sdata[2], sdata[1], sdata[0]};

  mfp_ahb_xbar_n #(
    .N_SLV(NS), .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT_CYCLES(8)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus),
    .TO_CLR(TO_CLR), .TO_FLAG(TO_FLAG), .TO_SLV(TO_SLV)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [5:0]  hro;
    logic [5:0]  hrs;
    logic [5:0]  hsel;
    logic        rdy;
    logic        rsp;
    logic [31:0] rd;
  } vec_t;

  vec_t tv [22];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int ref_decode(logic [31:0] a);
    for (int i = 0; i < NS; i++) begin
      if ((a & m_mask[i]) == (m_base[i] & m_mask[i])) return i;
    end
    return -1;
  endfunction

  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(logic [31:0] a, logic [1:0] t, logic [5:0] hro, logic [5:0] hrs);
    bus.HADDR       = a;
    bus.HTRANS      = t;
    bus.HREADYOUT_S = hro;
    bus.HRESP_S     = hrs;
  endtask

  task automatic expect_rsp(string name, logic rdy, logic rsp, logic [31:0] rd);
    @(negedge HCLK);
    chk({name, ".hready"}, {31'h0, bus.HREADY}, {31'h0, rdy});
    chk({name, ".hresp"},  {31'h0, bus.HRESP},  {31'h0, rsp});
    chk({name, ".hrdata"}, bus.HRDATA, rd);
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    drive(32'h0, 2'd0, 6'h3F, 6'h00);
    next_cycle();
    next_cycle();
    HRESET = 1'b0;
  endtask

  initial begin
    int tgt;
    int age;
    int d;
    logic        e_rdy;
    logic        e_rsp;
    logic [31:0] e_rd;
    logic [5:0]  e_sel;
    logic [5:0]  hro_v;
    logic [5:0]  hrs_v;
    logic [31:0] a_v;

    sdata[0] = 32'h11111111; sdata[1] = 32'h000000A5; sdata[2] = 32'h22222222;
    sdata[3] = 32'h33333333; sdata[4] = 32'h44444444; sdata[5] = 32'h55555555;
    TO_CLR = 1'b0;

    //        addr          trans hro    hrs    hsel       rdy   rsp   rdata
    tv[0]  = '{32'h00000000, 2'd0, 6'h3F, 6'h00, 6'b000001, 1'b1, 1'b0, 32'h0};
    tv[1]  = '{32'hBF800000, 2'd2, 6'h3F, 6'h00, 6'b000010, 1'b1, 1'b0, 32'h0};
    tv[2]  = '{32'h00000000, 2'd0, 6'h3F, 6'h00, 6'b000001, 1'b1, 1'b0, 32'h000000A5};
    tv[3]  = '{32'hBF700010, 2'd2, 6'h3F, 6'h00, 6'b000100, 1'b1, 1'b0, 32'h0};
    tv[4]  = '{32'h00000100, 2'd2, 6'h3B, 6'h00, 6'b000001, 1'b0, 1'b0, 32'h22222222};
    tv[5]  = '{32'h00000100, 2'd2, 6'h3B, 6'h00, 6'b000001, 1'b0, 1'b0, 32'h22222222};
    tv[6]  = '{32'h00000100, 2'd2, 6'h3B, 6'h00, 6'b000001, 1'b0, 1'b0, 32'h22222222};
    tv[7]  = '{32'h00000100, 2'd2, 6'h3F, 6'h00, 6'b000001, 1'b1, 1'b0, 32'h22222222};
    tv[8]  = '{32'h10000000, 2'd2, 6'h3F, 6'h00, 6'b000000, 1'b1, 1'b0, 32'h11111111};
    tv[9]  = '{32'hBF800000, 2'd2, 6'h3F, 6'h00, 6'b000010, 1'b0, 1'b1, 32'h0};
    tv[10] = '{32'hBF800000, 2'd2, 6'h3F, 6'h00, 6'b000010, 1'b1, 1'b1, 32'h0};
    tv[11] = '{32'h00000000, 2'd0, 6'h3F, 6'h00, 6'b000001, 1'b1, 1'b0, 32'h000000A5};
    tv[12] = '{32'hBF730000, 2'd0, 6'h3F, 6'h00, 6'b100000, 1'b1, 1'b0, 32'h0};
    tv[13] = '{32'hBF710000, 2'd2, 6'h3F, 6'h00, 6'b001000, 1'b1, 1'b0, 32'h0};
    tv[14] = '{32'h00000000, 2'd0, 6'h37, 6'h08, 6'b000001, 1'b0, 1'b1, 32'h33333333};
    tv[15] = '{32'h00000000, 2'd0, 6'h3F, 6'h08, 6'b000001, 1'b1, 1'b1, 32'h33333333};
    tv[16] = '{32'h10000000, 2'd2, 6'h3F, 6'h00, 6'b000000, 1'b1, 1'b0, 32'h0};
    tv[17] = '{32'h10000004, 2'd3, 6'h3F, 6'h00, 6'b000000, 1'b0, 1'b1, 32'h0};
    tv[18] = '{32'h10000004, 2'd3, 6'h3F, 6'h00, 6'b000000, 1'b1, 1'b1, 32'h0};
    tv[19] = '{32'h00000000, 2'd0, 6'h3F, 6'h00, 6'b000001, 1'b0, 1'b1, 32'h0};
    tv[20] = '{32'h00000000, 2'd0, 6'h3F, 6'h00, 6'b000001, 1'b1, 1'b1, 32'h0};
    tv[21] = '{32'h00000000, 2'd1, 6'h3F, 6'h00, 6'b000001, 1'b1, 1'b0, 32'h0};

    // ---------------- directed table ----------------
    do_reset();
    for (int i = 0; i < 22; i++) begin
      drive(tv[i].addr, tv[i].trans, tv[i].hro, tv[i].hrs);
      @(negedge HCLK);
      chk($sformatf("tv%0d.hsel", i),   {26'h0, bus.HSEL_S}, {26'h0, tv[i].hsel});
      chk($sformatf("tv%0d.hready", i), {31'h0, bus.HREADY}, {31'h0, tv[i].rdy});
      chk($sformatf("tv%0d.hresp", i),  {31'h0, bus.HRESP},  {31'h0, tv[i].rsp});
      chk($sformatf("tv%0d.hrdata", i), bus.HRDATA, tv[i].rd);
      next_cycle();
    end

    // ---------------- reset during ERR1 ----------------
    do_reset();
    drive(32'h10000000, 2'd2, 6'h3F, 6'h00);
    expect_rsp("rst_err.accept", 1'b1, 1'b0, 32'h0);
    next_cycle();
    drive(32'h0, 2'd0, 6'h3F, 6'h00);
    HRESET = 1'b1;
    expect_rsp("rst_err.err1", 1'b0, 1'b1, 32'h0);
    next_cycle();
    HRESET = 1'b0;
    expect_rsp("rst_err.after", 1'b1, 1'b0, 32'h0);
    next_cycle();
    expect_rsp("rst_err.idle", 1'b1, 1'b0, 32'h0);
    next_cycle();

    // ---------------- reset during a slave stall ----------------
    drive(32'hBF700000, 2'd2, 6'h3F, 6'h00);
    next_cycle();
    drive(32'h0, 2'd0, 6'h3B, 6'h00);
    HRESET = 1'b1;
    expect_rsp("rst_stall.stall", 1'b0, 1'b0, 32'h22222222);
    next_cycle();
    HRESET = 1'b0;
    expect_rsp("rst_stall.after", 1'b1, 1'b0, 32'h0);
    next_cycle();

    // ---------------- long stall on slave 3 ----------------
    drive(32'hBF710000, 2'd2, 6'h3F, 6'h00);
    next_cycle();
    drive(32'h0, 2'd0, 6'h37, 6'h00);
`ifdef MFP_AHB_XBAR_TIMEOUT_EN
    for (int k = 0; k < 8; k++) begin
      expect_rsp($sformatf("to.stall%0d", k), 1'b0, 1'b0, 32'h33333333);
      chk($sformatf("to.flag_pre%0d", k), {31'h0, TO_FLAG}, 32'h0);
      next_cycle();
    end
    expect_rsp("to.err1", 1'b0, 1'b1, 32'h0);
    chk("to.flag_set", {31'h0, TO_FLAG}, 32'h1);
    chk("to.slv_set",  {28'h0, TO_SLV},  32'h3);
    next_cycle();
    TO_CLR = 1'b1;
    expect_rsp("to.err2", 1'b1, 1'b1, 32'h0);
    next_cycle();
    TO_CLR = 1'b0;
    expect_rsp("to.idle", 1'b1, 1'b0, 32'h0);
    chk("to.flag_clr", {31'h0, TO_FLAG}, 32'h0);
    chk("to.slv_clr",  {28'h0, TO_SLV},  32'h0);
    next_cycle();
`else
    for (int k = 0; k < 20; k++) begin
      TO_CLR = (k == 10);
      expect_rsp($sformatf("stall%0d", k), 1'b0, 1'b0, 32'h33333333);
      next_cycle();
    end
    TO_CLR = 1'b0;
    drive(32'h0, 2'd0, 6'h3F, 6'h00);
    expect_rsp("stall.release", 1'b1, 1'b0, 32'h33333333);
    chk("stall.to_flag", {31'h0, TO_FLAG}, 32'h0);
    chk("stall.to_slv",  {28'h0, TO_SLV},  32'h0);
    next_cycle();
`endif

    // ---------------- randomized run vs. transfer-level model ----------------
    // tgt: -2 no transfer in data phase, -1 default slave, else slave index.
    // age: cycles the current data phase has already lasted.
    do_reset();
    tgt = -2;
    age = 0;
    for (int c = 0; c < 2000; c++) begin
      case ($urandom_range(0, 5))
        0:       a_v = $urandom & 32'h000FFFFC;
        1:       a_v = 32'hBF800000 | 32'($urandom_range(0, 7));
        2:       a_v = 32'hBF700000 | ($urandom & 32'h0003FFFC);
        3:       a_v = 32'hBF740000 | ($urandom & 32'h0000FFFC);
        default: a_v = $urandom;
      endcase
      for (int s = 0; s < NS; s++) begin
        sdata[s] = $urandom;
        hro_v[s] = ($urandom_range(0, 3) != 0);
        hrs_v[s] = ($urandom_range(0, 7) == 0);
      end
      // Keep stalls short so no watchdog can fire in this phase.
      if (tgt >= 0 && age >= 4) hro_v[tgt] = 1'b1;
      drive(a_v, 2'($urandom_range(0, 3)), hro_v, hrs_v);

      d     = ref_decode(a_v);
      e_sel = (d < 0) ? 6'h00 : (6'h01 << d);
      if (tgt == -2) begin
        e_rdy = 1'b1; e_rsp = 1'b0; e_rd = 32'h0;
      end else if (tgt == -1) begin
        e_rdy = (age != 0); e_rsp = 1'b1; e_rd = 32'h0;
      end else begin
        e_rdy = hro_v[tgt]; e_rsp = hrs_v[tgt]; e_rd = sdata[tgt];
      end

      @(negedge HCLK);
      chk($sformatf("rnd%0d.hsel", c),   {26'h0, bus.HSEL_S}, {26'h0, e_sel});
      chk($sformatf("rnd%0d.hready", c), {31'h0, bus.HREADY}, {31'h0, e_rdy});
      chk($sformatf("rnd%0d.hresp", c),  {31'h0, bus.HRESP},  {31'h0, e_rsp});
      chk($sformatf("rnd%0d.hrdata", c), bus.HRDATA, e_rd);
      if (c % 100 == 0) chk($sformatf("rnd%0d.to_flag", c), {31'h0, TO_FLAG}, 32'h0);

      if (e_rdy) begin
        if (!bus.HTRANS[1]) tgt = -2;
        else                tgt = d;
        age = 0;
      end else begin
        age++;
      end
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
